irq_controller: RTL



---
 rtl/irq_controller.sv | 104 ++++++++++
 1 files changed

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - 8-source edge/level interrupt aggregator with CPU register slave
// Drives a registered active-low IRQ toward the 65C02 IRQB pin.
module irq_controller #(
  parameter int NUM_SRC = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cs,
  input  logic               i_rwb,
  input  logic [1:0]         i_addr,
  input  logic [7:0]         i_data,
  output logic [7:0]         o_data,
  input  logic [NUM_SRC-1:0] i_irqb,
  output logic               o_irqb
);

  localparam logic [7:0] SRC_MASK = 8'((9'd1 << NUM_SRC) - 9'd1);

  logic [7:0] irqb_ext;
  logic [7:0] prev_irqb_q, prev_irqb_d;
  logic [7:0] pending_q, pending_d;
  logic [7:0] enable_q, enable_d;
  logic [7:0] mode_q, mode_d;
  logic       o_irqb_q, o_irqb_d;

  logic       wr_en;
  logic [7:0] fell;
  logic [7:0] clr;
  logic [7:0] new_edge;
  logic [7:0] active;
  logic       vec_valid;
  logic [2:0] vec_idx;

  // Absent sources look permanently idle (high) so they never latch.
  for (genvar g = 0; g < 8; g++) begin : g_ext
    if (g < NUM_SRC) begin : g_src
      assign irqb_ext[g] = i_irqb[g];
    end else begin : g_tie
      assign irqb_ext[g] = 1'b1;
    end
  end

  always_comb begin
    wr_en       = i_cs & ~i_rwb;
    enable_d    = enable_q;
    mode_d      = mode_q;
    clr         = 8'h00;
    prev_irqb_d = irqb_ext;

    if (wr_en && i_addr == 2'd1) enable_d = i_data & SRC_MASK;
    if (wr_en && i_addr == 2'd2) mode_d   = i_data & SRC_MASK;
    if (wr_en && i_addr == 2'd0) clr      = i_data;
    if (wr_en && i_addr == 2'd3) clr      = 8'd1 << i_data[2:0];

    fell     = prev_irqb_q & ~irqb_ext;
    // Bits switching to edge mode drop any stale level pending; a same-cycle edge still sets.
    new_edge = mode_d & ~mode_q;

    pending_d = (mode_d & (fell | (pending_q & ~clr & ~new_edge)))
              | (~mode_d & ~irqb_ext);
    pending_d = pending_d & SRC_MASK;

    active   = pending_q & enable_q;
    o_irqb_d = ~|active;
  end

  always_comb begin
    vec_valid = |active;
    vec_idx   = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) vec_idx = 3'(i);
    end
  end

  always_comb begin
    o_data = 8'h00;
    case (i_addr)
      2'd0: o_data = pending_q;
      2'd1: o_data = enable_q;
      2'd2: o_data = mode_q;
      2'd3: o_data = vec_valid ? {1'b1, 4'b0000, vec_idx} : 8'h00;
      default: o_data = 8'h00;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prev_irqb_q <= 8'hFF;
      pending_q   <= 8'h00;
      enable_q    <= 8'h00;
      mode_q      <= 8'h00;
      o_irqb_q    <= 1'b1;
    end else begin
      prev_irqb_q <= prev_irqb_d;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      o_irqb_q    <= o_irqb_d;
    end
  end

  assign o_irqb = o_irqb_q;

endmodule
